// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// FSM states, Booth digit encoding and digit-count helper.
package booth_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } digit_e;

    function automatic int num_digits(input int width);
        return width / 2 + 1;
    endfunction

    function automatic digit_e decode(input logic [2:0] win);
        digit_e d;
        d = ZERO;
        unique case (win)
            3'b000, 3'b111: d = ZERO;
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_mul_seq_digit_sel.sv
// Radix-4 Booth partial-product selector: maps a 3-bit multiplier
// window onto 0, +/-M or +/-2M at full accumulator width.
module booth_digit_sel
    import booth_mul_pkg::*;
#(
    parameter int PW = 34
) (
    input  logic [2:0]    window,
    input  logic [PW-1:0] m,
    output logic [PW-1:0] pp
);

    digit_e digit;

    assign digit = decode(window);

    always_comb begin
        pp = '0;
        unique case (digit)
            ZERO:    pp = '0;
            POS1:    pp = m;
            POS2:    pp = m << 1;
            NEG1:    pp = -m;
            NEG2:    pp = -(m << 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, valid/ready
// on both sides. Define BOOTH_MUL_SEQ_EARLY_TERM_EN for early exit.
module booth_mul_seq
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod
);

    localparam int PW = 2 * WIDTH + 2;
    localparam int QW = WIDTH + 3;
    localparam int N  = num_digits(WIDTH);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e          state;
    state_e          state_n;
    logic [PW-1:0]   m;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   pp;
    logic [QW-1:0]   q;
    logic [QW-1:0]   q_sh;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            last;
    logic            ext;
    logic            unused_acc_top;

    assign in_ready  = rst_n & ((state == IDLE) |
                                ((state == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    assign out_prod  = acc[2*WIDTH-1:0];
    assign ext       = in_signed & in_b[WIDTH-1];
    assign q_sh      = {{2{q[QW-1]}}, q[QW-1:2]};

    // Guard bits above the product only keep the modular sum exact.
    assign unused_acc_top = ^acc[PW-1:2*WIDTH];

`ifdef BOOTH_MUL_SEQ_EARLY_TERM_EN
    // Once Q is pure sign, every remaining digit decodes to zero.
    assign last = (cnt == LAST) | (q_sh == '0) | (&q_sh);
`else
    assign last = (cnt == LAST);
`endif

    booth_digit_sel #(
        .PW(PW)
    ) u_sel (
        .window(q[2:0]),
        .m     (m),
        .pp    (pp)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = BUSY;
            BUSY:    if (last) state_n = DONE;
            DONE: begin
                if (accept)         state_n = BUSY;
                else if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            m     <= '0;
            q     <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                m   <= in_signed ? {{(WIDTH+2){in_a[WIDTH-1]}}, in_a}
                                 : {{(WIDTH+2){1'b0}}, in_a};
                q   <= {ext, ext, in_b, 1'b0};
                acc <= '0;
                cnt <= '0;
            end else if (state == BUSY) begin
                acc <= acc + pp;
                m   <= m << 2;
                q   <= q_sh;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq (WIDTH=16): directed vector table,
// backpressure, mid-BUSY reset and randomised operand/handshake gaps.
module tb_booth_mul_seq;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic           in_signed;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_prod;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    booth_mul_seq #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_signed(in_signed),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_prod (out_prod)
    );

    typedef struct {
        logic         sgn;
        logic [15:0]  a;
        logic [15:0]  b;
        logic [31:0]  exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic sgn,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
        longint sa;
        longint sb;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        return 32'(sa * sb);
    endfunction

    // Accept one operand pair and wait for out_valid; lat counts edges
    // from the accept edge. Leaves the product unconsumed.
    task automatic run_op(input logic sgn, input logic [15:0] a,
                          input logic [15:0] b, output int lat);
        @(negedge clk);
        in_signed = sgn;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        while (!in_ready) @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            if (!out_valid) lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    vec_t vecs[12];

    initial begin
        int lat;
        logic [31:0] held;

        vecs[0]  = '{1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB};
        vecs[1]  = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2]  = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[3]  = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
        vecs[4]  = '{1'b0, 16'h8000, 16'h8000, 32'h40000000};
        vecs[5]  = '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000};
        vecs[6]  = '{1'b0, 16'h1234, 16'h0000, 32'h00000000};
        vecs[7]  = '{1'b1, 16'h0005, 16'h0003, 32'h0000000F};
        vecs[8]  = '{1'b0, 16'h0001, 16'h8000, 32'h00008000};
        vecs[9]  = '{1'b1, 16'h8000, 16'h0001, 32'hFFFF8000};
        vecs[10] = '{1'b0, 16'hFFFF, 16'h0002, 32'h0001FFFE};
        vecs[11] = '{1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        @(negedge clk);
        check("in_ready_in_reset", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_prod", 64'(out_prod), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_prod", i), 64'(out_prod),
                  64'(vecs[i].exp));
`ifndef BOOTH_MUL_SEQ_EARLY_TERM_EN
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
`endif
            consume();
            check($sformatf("vec%0d_valid_drop", i), 64'(out_valid), 64'd0);
        end

        // Backpressure, then output handshake and accept on one edge.
        run_op(1'b1, 16'hFFFD, 16'h0007, lat);
        held = out_prod;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_prod_stable", 64'(out_prod), 64'(held));
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_signed = 1'b0;
        in_a      = 16'd2;
        in_b      = 16'd3;
        #1;
        check("bp_in_ready_comb", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("bp_valid_low_after", 64'(out_valid), 64'd0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            if (!out_valid) lat++;
        end
        check("bp_next_prod", 64'(out_prod), 64'd6);
`ifndef BOOTH_MUL_SEQ_EARLY_TERM_EN
        check("bp_next_latency", 64'(lat), 64'd9);
`endif
        consume();

        // Reset asserted mid-BUSY.
        @(negedge clk);
        in_signed = 1'b0;
        in_a      = 16'hFFFF;
        in_b      = 16'hFFFF;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_prod", 64'(out_prod), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready_rel", 64'(in_ready), 64'd1);
        begin
            int stale = 0;
            repeat (15) begin
                @(negedge clk);
                if (out_valid) stale++;
            end
            check("midrst_no_stale", 64'(stale), 64'd0);
        end

`ifdef BOOTH_MUL_SEQ_EARLY_TERM_EN
        run_op(1'b1, 16'h1234, 16'h0000, lat);
        check("et_zero_prod", 64'(out_prod), 64'd0);
        check("et_zero_lat", 64'(lat), 64'd1);
        consume();
        run_op(1'b1, 16'h0005, 16'h0003, lat);
        check("et_5x3_prod", 64'(out_prod), 64'd15);
        check("et_5x3_lat", 64'(lat), 64'd2);
        consume();
        run_op(1'b0, 16'h0001, 16'h8000, lat);
        check("et_msb_prod", 64'(out_prod), 64'h8000);
        check("et_msb_lat", 64'(lat), 64'd9);
        consume();
`endif

        // Random operands with random input and output gaps.
        for (int i = 0; i < 1000; i++) begin
            logic        s;
            logic [15:0] a;
            logic [15:0] b;
            s = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(s, a, b, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            check($sformatf("rand%0d s=%0d a=%0h b=%0h", i, s, a, b),
                  64'(out_prod), 64'(ref_mul(s, a, b)));
            consume();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
